serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Bit-serial add/subtract sequencer. Holds one 1-bit full-adder cell and a carry flop.
- Drives that cell for WIDTH cycles, LSB first, to produce a WIDTH-bit sum.
- Trades area for latency in the arithmetic lab datapath. Start/done handshake toward the surrounding control FSM.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..64.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when ready (IDLE or DONE)
- sub  input  1  0 = a+b+cin; 1 = a-b (b inverted, carry-in forced 1, cin ignored)
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in for add mode, captured on accepted start
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse in DONE
- sum  output  WIDTH  result; valid from done, held until the next accepted start
- cout  output  1  final carry out; for sub, 1 = no borrow

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset: state = IDLE; busy, done, cout = 0; sum = 0; internal operand regs, carry and bit counter = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1:
  - Capture opA = a and opB = (sub ? ~b : b).
  - Set carry = (sub ? 1 : cin).
  - Set cnt = 0, clear sum, go to RUN.
- IDLE, start=0: stay in IDLE; sum and cout hold.
- RUN, each cycle:
  - Cell inputs are opA[0], opB[0], carry.
  - sum shifts right with cell s entering sum[WIDTH-1].
  - opA and opB shift right (zero fill).
  - carry = cell cout.
  - cnt increments.
- RUN, cnt == WIDTH-1: after that cycle's update, go to DONE. Load cout with the final cell carry on the same edge.
- DONE: done=1 for exactly one cycle.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back operation) and the FSM goes to RUN.
  - Otherwise the FSM goes to IDLE.
- Latency: start sampled on edge E. The FSM is in RUN for WIDTH cycles and done is high in the cycle after edge E+WIDTH. Throughput is one operation per WIDTH+1 cycles.
- start while busy: ignored. No queuing, no error flag. Captured operands are unaffected.
- a, b, sub and cin are don't-care except on the accepting edge.
- sum is not valid while busy (partial shift contents visible). Consumers use done.
- reset asserted mid-RUN: abort on that edge; all outputs return to reset values. No done pulse.
- cnt width: $clog2(WIDTH). Wrap never occurs because RUN exits at WIDTH-1.

Optional Feature:
- Macro SERIAL_ADD_OVF_EN.
- Defined: extra output port ovf (1 bit) = signed overflow. Compute it as the carry into the MSB bit XOR the carry out of the MSB bit, captured on the final RUN edge alongside cout. It resets to 0 and holds with sum.
- Undefined: port absent, no extra flop.

Decomposition:
- Package serial_add_pkg:
  - typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t
  - localparam default WIDTH
- One sub-module serial_add_bit: the combinational 1-bit full adder (a, b, cin -> s, cout), gate-level. It is instantiated once.
- Carry flop, shift registers and FSM live in serial_add_ctrl.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, cin=0, sub=0 -> sum=0x96, cout=0. done exactly 9 cycles after the start edge; busy high for 8 cycles.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; then a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
- sub=1, a=0x10, b=0x20 -> sum=0xF0, cout=0 (borrow); sub=1, a=0x20, b=0x10 -> sum=0x10, cout=1.
- Pulse start with new operands at cycle 3 of RUN -> ignored; result matches the first operation. start held during DONE -> second operation accepted, its done follows 9 cycles after the first done.
- Assert reset at RUN cycle 4 -> next cycle busy=0, done=0, sum=0, cout=0. No done pulse afterwards; a new start then completes normally.
- SERIAL_ADD_OVF_EN defined: a=0x7F, b=0x01 -> sum=0x80, ovf=1, cout=0; a=0xFF, b=0x01 -> ovf=0, cout=1.

Source files
------------

// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared state encoding and default width for the bit-serial adder.
package serial_add_pkg;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/serial_add_bit.sv
// serial_add_bit: gate-level 1-bit full adder cell.
module serial_add_bit (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic cout_o
);
    logic p;
    assign p      = a_i ^ b_i;
    assign s_o    = p ^ cin_i;
    assign cout_o = (a_i & b_i) | (cin_i & p);
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract sequencer, LSB first, one cell reused WIDTH cycles.
// Define SERIAL_ADD_OVF_EN to add the signed-overflow output ovf.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH);
    state_t           state_q;
    logic [WIDTH-1:0] opa_q, opb_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             cell_s, cell_co;
    serial_add_bit u_bit (
        .a_i   (opa_q[0]),
        .b_i   (opb_q[0]),
        .cin_i (carry_q),
        .s_o   (cell_s),
        .cout_o(cell_co)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_ADD_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state_q)
                S_RUN: begin
                    sum     <= {cell_s, sum[WIDTH-1:1]};
                    opa_q   <= opa_q >> 1;
                    opb_q   <= opb_q >> 1;
                    carry_q <= cell_co;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        cout    <= cell_co;
`ifdef SERIAL_ADD_OVF_EN
                        // carry_q is the carry into the MSB on this final step
                        ovf     <= carry_q ^ cell_co;
`endif
                    end
                end
                default: begin
                    if (start) begin
                        state_q <= S_RUN;
                        busy    <= 1'b1;
                        opa_q   <= a;
                        opb_q   <= sub ? ~b : b;
                        carry_q <= sub | cin;
                        cnt_q   <= '0;
                        sum     <= '0;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed self-checking bench for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       sub = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    logic       busy, done, cout;
    logic [7:0] sum;
`ifdef SERIAL_ADD_OVF_EN
    logic       ovf;
`endif
    int errors = 0;
    int checks = 0;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .sub  (sub),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf  (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Drive a start at the current negedge; returns at the first negedge after the accepting edge.
    task automatic launch(input logic [7:0] a_v, input logic [7:0] b_v, input logic cin_v, input logic sub_v);
        a = a_v; b = b_v; cin = cin_v; sub = sub_v; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 8'hxx; b = 8'hxx; cin = 1'bx; sub = 1'bx;
    endtask

    // Waits (bounded) for done; lat counts negedges waited, bc counts busy-high samples seen.
    task automatic wait_done(output int lat, output int bc);
        lat = 0;
        bc = int'(busy);
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
            bc += int'(busy);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (sum !== 8'h00) begin errors++; $display("FAIL reset_sum got=%h exp=00", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b exp=0", cout); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add;
        int lat, bc;
        launch(8'h5A, 8'h3C, 1'b0, 1'b0);
        wait_done(lat, bc);
        checks++; if (lat !== 8) begin errors++; $display("FAIL add_latency got=%0d exp=8 (done 9 cycles after start edge)", lat); end
        checks++; if (bc !== 8) begin errors++; $display("FAIL add_busy_cycles got=%0d exp=8", bc); end
        checks++; if (sum !== 8'h96) begin errors++; $display("FAIL add_sum got=%h exp=96", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL add_cout got=%b exp=0", cout); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL add_done_pulse got=%b exp=0", done); end
    endtask

    task automatic test_carry;
        int lat, bc;
        launch(8'hFF, 8'h01, 1'b0, 1'b0);
        wait_done(lat, bc);
        checks++; if (sum !== 8'h00) begin errors++; $display("FAIL carry_sum got=%h exp=00", sum); end
        checks++; if (cout !== 1'b1) begin errors++; $display("FAIL carry_cout got=%b exp=1", cout); end
        repeat (3) @(negedge clk);
        checks++; if ({sum, cout} !== 9'h001) begin errors++; $display("FAIL carry_hold got=%h exp=001", {sum, cout}); end
        launch(8'h00, 8'h00, 1'b1, 1'b0);
        wait_done(lat, bc);
        checks++; if (sum !== 8'h01) begin errors++; $display("FAIL cin_sum got=%h exp=01", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL cin_cout got=%b exp=0", cout); end
        @(negedge clk);
    endtask

    task automatic test_sub;
        int lat, bc;
        launch(8'h10, 8'h20, 1'b0, 1'b1);
        wait_done(lat, bc);
        checks++; if (sum !== 8'hF0) begin errors++; $display("FAIL sub_borrow_sum got=%h exp=f0", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL sub_borrow_cout got=%b exp=0", cout); end
        @(negedge clk);
        launch(8'h20, 8'h10, 1'b0, 1'b1);
        wait_done(lat, bc);
        checks++; if (sum !== 8'h10) begin errors++; $display("FAIL sub_sum got=%h exp=10", sum); end
        checks++; if (cout !== 1'b1) begin errors++; $display("FAIL sub_cout got=%b exp=1", cout); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int lat, bc;
        launch(8'h11, 8'h22, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        a = 8'hFF; b = 8'hFF; cin = 1'b1; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bc);
        checks++; if (lat !== 5) begin errors++; $display("FAIL ignore_latency got=%0d exp=5", lat); end
        checks++; if (sum !== 8'h33) begin errors++; $display("FAIL ignore_sum got=%h exp=33", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL ignore_cout got=%b exp=0", cout); end
        launch(8'h81, 8'h82, 1'b0, 1'b0);
        wait_done(lat, bc);
        checks++; if (lat !== 8) begin errors++; $display("FAIL b2b_latency got=%0d exp=8", lat); end
        checks++; if (sum !== 8'h03) begin errors++; $display("FAIL b2b_sum got=%h exp=03", sum); end
        checks++; if (cout !== 1'b1) begin errors++; $display("FAIL b2b_cout got=%b exp=1", cout); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int lat, bc, pulses;
        launch(8'h5A, 8'h3C, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b exp=0", done); end
        checks++; if (sum !== 8'h00) begin errors++; $display("FAIL midrst_sum got=%h exp=00", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL midrst_cout got=%b exp=0", cout); end
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            pulses += int'(done);
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_no_done got=%0d exp=0", pulses); end
        launch(8'h12, 8'h34, 1'b0, 1'b0);
        wait_done(lat, bc);
        checks++; if (lat !== 8) begin errors++; $display("FAIL midrst_restart_latency got=%0d exp=8", lat); end
        checks++; if (sum !== 8'h46) begin errors++; $display("FAIL midrst_restart_sum got=%h exp=46", sum); end
        @(negedge clk);
    endtask

`ifdef SERIAL_ADD_OVF_EN
    task automatic test_ovf;
        int lat, bc;
        launch(8'h7F, 8'h01, 1'b0, 1'b0);
        wait_done(lat, bc);
        checks++; if (sum !== 8'h80) begin errors++; $display("FAIL ovf_sum got=%h exp=80", sum); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", ovf); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL ovf_cout got=%b exp=0", cout); end
        @(negedge clk);
        launch(8'hFF, 8'h01, 1'b0, 1'b0);
        wait_done(lat, bc);
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", ovf); end
        checks++; if (cout !== 1'b1) begin errors++; $display("FAIL ovf_cout2 got=%b exp=1", cout); end
        @(negedge clk);
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset;
        test_add;
        test_carry;
        test_sub;
        test_back_to_back;
        test_reset_mid;
`ifdef SERIAL_ADD_OVF_EN
        test_ovf;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
